// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : sequencer states (IDLE, SHIFT, DONE)
//   cnt_width : bit-counter width for a given operand width, never below 1
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? unsigned'($clog2(width)) : 1;
  endfunction

endpackage

// File: rtl/add_serial_if.sv
// Handshake/operand bundle between the ALU controller and add_serial.
//   start, a, b, carry_in       : request and operands (controller -> adder)
//   busy, done                  : status (adder -> controller)
//   out, carry_out, overflow    : result, held until the next result
interface add_serial_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, out, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, out, carry_out, overflow
  );
endinterface

// File: rtl/add_serial_add1.sv
// One-bit full adder slice.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_serial.sv
// Bit-serial adder: one add1 slice, LSB first, one bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : add_serial_if slave (start/a/b/carry_in in, busy/done/out/carry_out/overflow out)
// An accepted start is followed by WIDTH SHIFT edges; done pulses for one
// cycle after the last one. Results are held until the next result.
module add_serial
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  add_serial_if.slave  bus
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [WIDTH-1:0] a_nx, b_nx, s_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             slice_s, slice_c;
  logic             last_bit;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_out_q, overflow_q;

  add1 u_slice (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign last_bit = (count == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (last_bit)  state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
      done_q <= (state_nx == DONE);
    end
  end

  // Sum bit enters at the MSB; written as shift-then-patch so WIDTH=1 works.
  always_comb begin
    a_nx            = a_sr >> 1;
    b_nx            = b_sr >> 1;
    s_nx            = s_sr >> 1;
    s_nx[WIDTH-1]   = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr        <= '0;
      b_sr        <= '0;
      s_sr        <= '0;
      carry       <= 1'b0;
      count       <= '0;
      out_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.carry_in;
            count <= '0;
          end
        end
        SHIFT: begin
          a_sr  <= a_nx;
          b_sr  <= b_nx;
          s_sr  <= s_nx;
          carry <= slice_c;
          if (last_bit) begin
            out_q       <= s_nx;
            carry_out_q <= slice_c;
            // carry still holds the carry into the MSB during the last bit
            overflow_q  <= slice_c ^ carry;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: a WIDTH=4 and a WIDTH=1 instance
// checked against an arithmetic reference model.
module tb_add_serial;

  localparam int unsigned W  = 4;
  localparam int          WI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_serial_if #(.WIDTH(W)) bus4 ();
  add_serial_if #(.WIDTH(1)) bus1 ();

  add_serial #(.WIDTH(W)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  add_serial #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_out4, exp_out1;
  logic        exp_co4, exp_ov4, exp_co1, exp_ov1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic model: modulo sum, unsigned carry, two's-complement overflow.
  function automatic void ref_add(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] s, output logic co,
                                  output logic ov);
    logic [32:0] mask, full;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, cin};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [31:0] s;
    logic co, ov, seen;
    int unsigned k;
    ref_add(W, 32'(a), 32'(b), cin, s, co, ov);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.carry_in = cin;
    @(negedge clk);
    bus4.start = 1'b0; bus4.a = 4'($urandom()); bus4.b = 4'($urandom()); bus4.carry_in = 1'($urandom());
    k = 1; seen = 1'b0;
    while (!seen && k <= W + 4) begin
      if (bus4.done) seen = 1'b1;
      else begin
        check("busy4", 32'(bus4.busy), 32'd1);
        check("stale_out4", 32'(bus4.out), exp_out4);
        @(negedge clk);
        k++;
      end
    end
    check("done_lat4", seen ? 32'(k) : 32'd0, 32'(W + 1));
    if (seen) begin
      check("busy_done4", 32'(bus4.busy), 32'd1);
      check("out4", 32'(bus4.out), s);
      check("cout4", 32'(bus4.carry_out), 32'(co));
      check("ovf4", 32'(bus4.overflow), 32'(ov));
    end
    exp_out4 = s; exp_co4 = co; exp_ov4 = ov;
    @(negedge clk);
    check("done_pulse4", 32'(bus4.done), 32'd0);
    check("busy_idle4", 32'(bus4.busy), 32'd0);
    check("held_out4", 32'(bus4.out), exp_out4);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin);
    logic [31:0] s;
    logic co, ov, seen;
    int unsigned k;
    ref_add(1, 32'(a), 32'(b), cin, s, co, ov);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.carry_in = cin;
    @(negedge clk);
    bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.carry_in = ~cin;
    k = 1; seen = 1'b0;
    while (!seen && k <= 5) begin
      if (bus1.done) seen = 1'b1;
      else begin
        check("busy1", 32'(bus1.busy), 32'd1);
        check("stale_out1", 32'(bus1.out), exp_out1);
        @(negedge clk);
        k++;
      end
    end
    check("done_lat1", seen ? 32'(k) : 32'd0, 32'd2);
    check("out1", 32'(bus1.out), s);
    check("cout1", 32'(bus1.carry_out), 32'(co));
    check("ovf1", 32'(bus1.overflow), 32'(ov));
    exp_out1 = s; exp_co1 = co; exp_ov1 = ov;
    @(negedge clk);
    check("done_pulse1", 32'(bus1.done), 32'd0);
  endtask

  logic [3:0] sa [64];
  logic [3:0] sb [64];
  logic       sc [64];

  initial begin
    logic [31:0] s;
    logic co, ov;
    int j;

    rst = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.carry_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
    exp_out4 = '0; exp_co4 = 1'b0; exp_ov4 = 1'b0;
    exp_out1 = '0; exp_co1 = 1'b0; exp_ov1 = 1'b0;
    #12;
    check("rst_out4", 32'(bus4.out), 32'd0);
    check("rst_flags4", 32'({bus4.busy, bus4.done, bus4.carry_out, bus4.overflow}), 32'd0);
    check("rst_flags1", 32'({bus1.busy, bus1.done, bus1.out, bus1.carry_out, bus1.overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op4(4'h3, 4'h5, 1'b0);
    op4(4'hF, 4'h1, 1'b0);
    op4(4'h7, 4'h0, 1'b1);
    op4(4'h8, 4'h8, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    for (int i = 0; i < 20; i++)
      op4(4'($urandom()), 4'($urandom()), 1'($urandom()));

    // Start held high, operands changing every cycle.
    for (int i = 0; i < 3 * (WI + 2) + WI + 2; i++) begin
      @(negedge clk);
      if (i >= WI + 1 && ((i - WI - 1) % (WI + 2)) == 0) begin
        j = i - WI - 1;
        ref_add(W, 32'(sa[j]), 32'(sb[j]), sc[j], s, co, ov);
        check("stream_done", 32'(bus4.done), 32'd1);
        check("stream_out", 32'(bus4.out), s);
        check("stream_cout", 32'(bus4.carry_out), 32'(co));
        check("stream_ovf", 32'(bus4.overflow), 32'(ov));
        exp_out4 = s; exp_co4 = co; exp_ov4 = ov;
      end else begin
        check("stream_nodone", 32'(bus4.done), 32'd0);
      end
      sa[i] = 4'($urandom()); sb[i] = 4'($urandom()); sc[i] = 1'($urandom());
      bus4.start = 1'b1; bus4.a = sa[i]; bus4.b = sb[i]; bus4.carry_in = sc[i];
    end
    @(negedge clk);
    bus4.start = 1'b0;

    // Asynchronous reset after two bits of an operation.
    op4(4'h6, 4'h6, 1'b0);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'hA; bus4.b = 4'h3; bus4.carry_in = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out4", 32'(bus4.out), 32'd0);
    check("arst_flags4", 32'({bus4.busy, bus4.done, bus4.carry_out, bus4.overflow}), 32'd0);
    check("arst_out1", 32'({bus1.out, bus1.carry_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_out4 = '0; exp_co4 = 1'b0; exp_ov4 = 1'b0;
    for (int i = 0; i < WI + 2; i++) begin
      @(negedge clk);
      check("arst_nodone", 32'({bus4.done, bus4.busy}), 32'd0);
    end
    op4(4'h2, 4'h2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
